// File: rtl/conv_line_sched.sv
// conv_line_sched: schedules row writes into a 4-deep line-RAM ring and paces
// the 3-row conv window reader for one frame.
//   clk, RESET        : clock, asynchronous active-high reset
//   frame_start       : pulse, starts a frame from IDLE
//   pix_valid/ready   : input pixel handshake (pix_ready is combinational)
//   pix_data          : RGB pixel, 3*bit_depth bits
//   wr_data/addr/en*  : registered line-RAM write port, one-hot RAM select
//   start_rd / fin_rd : run level to / window-done pulse from the conv datapath
//   frame_done        : one-cycle end-of-frame pulse
//   busy              : frame in progress
//   err_underrun      : sticky, a window finished before its next row was written
module conv_line_sched #(
    parameter int unsigned bit_depth    = 8,
    parameter logic [10:0] image_width  = 11'd28,
    parameter logic [10:0] image_height = 11'd28
) (
    input  logic                   clk,
    input  logic                   RESET,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [3*bit_depth-1:0] pix_data,
    output logic                   pix_ready,
    output logic [3*bit_depth-1:0] wr_data,
    output logic [10:0]            wr_addr,
    output logic                   wr_en0,
    output logic                   wr_en1,
    output logic                   wr_en2,
    output logic                   wr_en3,
    output logic                   start_rd,
    input  logic                   fin_rd,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   err_underrun
);

    localparam int unsigned pix_w = 3 * bit_depth;
    localparam int unsigned cnt_w = 11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]       state, state_nx;
    logic [cnt_w-1:0] col, col_nx;
    logic [cnt_w-1:0] row_wr, row_wr_nx;
    logic [cnt_w-1:0] win, win_nx;
    logic [3:0]       wr_en_q, wr_en_nx;
    logic [cnt_w-1:0] wr_addr_nx;
    logic [pix_w-1:0] wr_data_nx;
    logic             start_rd_nx, frame_done_nx, busy_nx, err_nx;

    logic             accept, row_end, fin_run, fin_last, underrun;
    logic [cnt_w:0]   win_lim, rows_eff;

    // Rows may run at most 4 ahead of the window being read (one extra bit avoids wrap).
    assign win_lim   = {1'b0, win} + 12'd4;
    assign pix_ready = ((state == ST_FILL) || (state == ST_RUN))
                     && ({1'b0, row_wr} < win_lim)
                     && (row_wr < image_height);

    assign accept   = pix_valid & pix_ready;
    assign row_end  = accept & (col == image_width - 11'd1);
    // Row count including a row completing in this very cycle.
    assign rows_eff = {1'b0, row_wr} + {11'd0, row_end};
    assign fin_run  = fin_rd & (state == ST_RUN);
    // The final window is the one that brings win to image_height-2.
    assign fin_last = fin_run & (win == image_height - 11'd3);
    assign underrun = fin_run & ~fin_last & (rows_eff < win_lim);

    assign wr_en0 = wr_en_q[0];
    assign wr_en1 = wr_en_q[1];
    assign wr_en2 = wr_en_q[2];
    assign wr_en3 = wr_en_q[3];

    // Next-state and next-output logic.
    always_comb begin
        state_nx      = state;
        col_nx        = col;
        row_wr_nx     = row_wr;
        win_nx        = win;
        wr_en_nx      = 4'b0000;
        wr_addr_nx    = wr_addr;
        wr_data_nx    = wr_data;
        start_rd_nx   = start_rd;
        frame_done_nx = 1'b0;
        err_nx        = err_underrun;

        if (accept) begin
            wr_en_nx   = 4'b0001 << row_wr[1:0];
            wr_addr_nx = col;
            wr_data_nx = pix_data;
            if (row_end) begin
                col_nx    = '0;
                row_wr_nx = row_wr + 11'd1;
            end else begin
                col_nx    = col + 11'd1;
            end
        end

        if (fin_run) begin
            win_nx = win + 11'd1;
            if (underrun) begin
                err_nx = 1'b1;
            end
        end

        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nx  = ST_FILL;
                    col_nx    = '0;
                    row_wr_nx = '0;
                    win_nx    = '0;
                end
            end
            ST_FILL: begin
                if (row_end && (row_wr == 11'd2)) begin
                    state_nx    = ST_RUN;
                    start_rd_nx = 1'b1;
                end
            end
            ST_RUN: begin
                if (fin_last) begin
                    state_nx      = ST_IDLE;
                    start_rd_nx   = 1'b0;
                    frame_done_nx = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state        <= ST_IDLE;
            col          <= '0;
            row_wr       <= '0;
            win          <= '0;
            wr_en_q      <= '0;
            wr_addr      <= '0;
            wr_data      <= '0;
            start_rd     <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            state        <= state_nx;
            col          <= col_nx;
            row_wr       <= row_wr_nx;
            win          <= win_nx;
            wr_en_q      <= wr_en_nx;
            wr_addr      <= wr_addr_nx;
            wr_data      <= wr_data_nx;
            start_rd     <= start_rd_nx;
            frame_done   <= frame_done_nx;
            busy         <= busy_nx;
            err_underrun <= err_nx;
        end
    end

endmodule

// File: tb/tb_conv_line_sched.sv
// Bench for conv_line_sched with a 4x6 image: directed scenarios plus random
// frames, checked against an integer model of rows, windows and write traffic.
module tb_conv_line_sched;

    localparam int unsigned BD = 8;
    localparam int unsigned PW = 3 * BD;
    localparam logic [10:0] W  = 11'd4;
    localparam logic [10:0] H  = 11'd6;
    localparam int WI = 4;
    localparam int HI = 6;

    logic          clk = 1'b0;
    logic          RESET = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic          fin_rd = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_ready;
    logic [PW-1:0] wr_data;
    logic [10:0]   wr_addr;
    logic          wr_en0, wr_en1, wr_en2, wr_en3;
    logic          start_rd, frame_done, busy, err_underrun;
    logic [3:0]    wr_en_v;

    assign wr_en_v = {wr_en3, wr_en2, wr_en1, wr_en0};

    always #5 clk = ~clk;

    conv_line_sched #(
        .bit_depth    (BD),
        .image_width  (W),
        .image_height (H)
    ) dut (
        .clk          (clk),
        .RESET        (RESET),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .wr_data      (wr_data),
        .wr_addr      (wr_addr),
        .wr_en0       (wr_en0),
        .wr_en1       (wr_en1),
        .wr_en2       (wr_en2),
        .wr_en3       (wr_en3),
        .start_rd     (start_rd),
        .fin_rd       (fin_rd),
        .frame_done   (frame_done),
        .busy         (busy),
        .err_underrun (err_underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame progress as plain counts.
    bit            m_in_frame, m_reading, m_err;
    int            m_rows, m_col, m_wins;
    logic [3:0]    e_wr_en;
    logic [10:0]   e_addr;
    logic [PW-1:0] e_data;
    bit            e_done;
    bit            g_ready_obs, g_ready_exp;

    function automatic bit model_ready();
        return m_in_frame && (m_rows < m_wins + 4) && (m_rows < HI);
    endfunction

    task automatic model_reset();
        m_in_frame = 0; m_reading = 0; m_err = 0;
        m_rows = 0; m_col = 0; m_wins = 0;
        e_wr_en = '0; e_addr = '0; e_data = '0; e_done = 0;
    endtask

    // One clock: drive inputs, sample pix_ready mid-cycle, advance the model.
    task automatic clk_step(input bit fs, input bit pv, input logic [PW-1:0] pd, input bit fr);
        bit acc, fin_ok, fin_last;
        frame_start = fs; pix_valid = pv; pix_data = pd; fin_rd = fr;
        g_ready_exp = model_ready();
        acc = pv && g_ready_exp;
        fin_ok = fr && m_reading;
        @(negedge clk);
        g_ready_obs = pix_ready;
        @(posedge clk);
        #1;
        frame_start = 0; pix_valid = 0; fin_rd = 0;
        e_wr_en = '0;
        e_done = 0;
        if (fs && !m_in_frame) begin
            m_in_frame = 1; m_rows = 0; m_col = 0; m_wins = 0;
        end
        if (acc) begin
            e_wr_en = 4'(1 << (m_rows % 4));
            e_addr = 11'(m_col);
            e_data = pd;
            m_col++;
            if (m_col == WI) begin
                m_col = 0;
                m_rows++;
                if (m_rows == 3) m_reading = 1;
            end
        end
        if (fin_ok) begin
            fin_last = (m_wins + 1 == HI - 2);
            if (!fin_last && (m_rows < m_wins + 4)) m_err = 1;
            m_wins++;
            if (fin_last) begin
                m_reading = 0; m_in_frame = 0; e_done = 1;
            end
        end
    endtask

    task automatic push_pixels(input int n);
        for (int i = 0; i < n; i++) clk_step(0, 1, PW'($urandom), 0);
    endtask

    // Streams pixels and underrun-safe fin_rd pulses until the frame ends.
    task automatic run_to_end(output int done_cnt, output bit timed_out);
        done_cnt = 0;
        timed_out = 1;
        for (int n = 0; n < 300; n++) begin
            clk_step(0, (m_rows < HI), PW'($urandom),
                     m_reading && ((m_rows >= m_wins + 4) || (m_rows == HI)) && ($urandom_range(1, 0) == 1));
            if (frame_done === 1'b1) done_cnt++;
            if (!m_in_frame) begin
                timed_out = 0;
                break;
            end
        end
        repeat (3) begin
            clk_step(0, 0, '0, 0);
            if (frame_done === 1'b1) done_cnt++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        RESET = 1;
        #2;
        n_cmp++;
        if ({pix_ready, start_rd, frame_done, busy, err_underrun, wr_en_v} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_pulse_outputs: got %b expected 0", {pix_ready, start_rd, frame_done, busy, err_underrun, wr_en_v});
        end
        @(negedge clk);
        RESET = 0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({pix_ready, start_rd, frame_done, busy, err_underrun} !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000", {pix_ready, start_rd, frame_done, busy, err_underrun});
        end
        n_cmp++;
        if (wr_en_v !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_wr_en: got %b expected 0000", wr_en_v);
        end
        n_cmp++;
        if (wr_addr !== 11'd0 || wr_data !== '0) begin
            n_bad++;
            $display("FAIL reset_wr_bus: got addr %0d data %0h expected 0 0", wr_addr, wr_data);
        end
        @(negedge clk);
        RESET = 0;
        @(posedge clk);
        #1;
        model_reset();
        clk_step(0, 1, PW'($urandom), 1);
        n_cmp++;
        if (busy !== 1'b0 || wr_en_v !== 4'd0 || g_ready_obs !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_wait: got busy %b en %b ready %b expected 0 0000 0", busy, wr_en_v, g_ready_obs);
        end
    endtask

    task automatic test_fill();
        logic [PW-1:0] pd;
        clk_step(1, 0, '0, 0);
        n_cmp++;
        if (busy !== 1'b1 || start_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_busy: got busy %b start %b expected 1 0", busy, start_rd);
        end
        for (int i = 0; i < 12; i++) begin
            pd = PW'($urandom);
            clk_step(0, 1, pd, 0);
            n_cmp++;
            if (g_ready_obs !== 1'b1 || wr_en_v !== 4'(1 << (i / 4)) || wr_addr !== 11'(i % 4) || wr_data !== pd) begin
                n_bad++;
                $display("FAIL fill_write_%0d: got rdy %b en %b addr %0d data %0h expected 1 %b %0d %0h",
                         i, g_ready_obs, wr_en_v, wr_addr, wr_data, 4'(1 << (i / 4)), i % 4, pd);
            end
            n_cmp++;
            if (start_rd !== (i == 11)) begin
                n_bad++;
                $display("FAIL fill_start_rd_%0d: got %b expected %b", i, start_rd, (i == 11));
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            clk_step(0, 1, PW'($urandom), 0);
            n_cmp++;
            if (wr_en_v !== 4'b1000 || wr_addr !== 11'(i)) begin
                n_bad++;
                $display("FAIL bp_row3_%0d: got en %b addr %0d expected 1000 %0d", i, wr_en_v, wr_addr, i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            clk_step(0, 1, PW'($urandom), 0);
            n_cmp++;
            if (g_ready_obs !== 1'b0 || wr_en_v !== 4'd0) begin
                n_bad++;
                $display("FAIL bp_stall_%0d: got rdy %b en %b expected 0 0000", i, g_ready_obs, wr_en_v);
            end
        end
        clk_step(0, 1, PW'($urandom), 1);
        clk_step(0, 1, PW'($urandom), 0);
        n_cmp++;
        if (g_ready_obs !== 1'b1 || wr_en_v !== 4'b0001 || wr_addr !== 11'd0 || err_underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_release: got rdy %b en %b addr %0d err %b expected 1 0001 0 0", g_ready_obs, wr_en_v, wr_addr, err_underrun);
        end
    endtask

    task automatic test_frame_end();
        int  done_cnt;
        bit  to;
        int  fins;
        fins = 0;
        to = 1;
        done_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            clk_step(0, (m_rows < HI), PW'($urandom),
                     m_reading && ((m_rows >= m_wins + 4) || (m_rows == HI)));
            n_cmp++;
            if (frame_done !== 1'(e_done) || start_rd !== 1'(m_reading)) begin
                n_bad++;
                $display("FAIL end_pulse_align: got done %b start %b expected %b %b", frame_done, start_rd, e_done, m_reading);
            end
            if (frame_done === 1'b1) done_cnt++;
            if (!m_in_frame) begin
                to = 0;
                break;
            end
        end
        repeat (3) begin
            clk_step(0, 0, '0, 0);
            if (frame_done === 1'b1) done_cnt++;
        end
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL end_timeout: got no frame end expected end within 300 cycles");
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_bad++;
            $display("FAIL end_done_count: got %0d expected 1", done_cnt);
        end
        n_cmp++;
        if (busy !== 1'b0 || start_rd !== 1'b0 || err_underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL end_state: got busy %b start %b err %b expected 0 0 0", busy, start_rd, err_underrun);
        end
        if (fins < 0) fins = 0;
    endtask

    task automatic test_underrun();
        int done_cnt;
        bit to;
        clk_step(1, 0, '0, 0);
        clk_step(0, 0, '0, 1);
        n_cmp++;
        if (err_underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL underrun_fin_in_fill: got %b expected 0", err_underrun);
        end
        push_pixels(12);
        clk_step(0, 0, '0, 1);
        n_cmp++;
        if (err_underrun !== 1'b1) begin
            n_bad++;
            $display("FAIL underrun_set: got %b expected 1", err_underrun);
        end
        run_to_end(done_cnt, to);
        n_cmp++;
        if (to || done_cnt != 1 || err_underrun !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL underrun_sticky_end: got to %b done %0d err %b busy %b expected 0 1 1 0", to, done_cnt, err_underrun, busy);
        end
        pulse_reset();
        n_cmp++;
        if (err_underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL underrun_cleared: got %b expected 0", err_underrun);
        end
    endtask

    task automatic test_simultaneous();
        int done_cnt;
        bit to;
        clk_step(1, 0, '0, 0);
        push_pixels(15);
        clk_step(0, 1, PW'($urandom), 1);
        n_cmp++;
        if (err_underrun !== 1'b0 || wr_en_v !== 4'b1000 || wr_addr !== 11'd3) begin
            n_bad++;
            $display("FAIL simul_no_underrun: got err %b en %b addr %0d expected 0 1000 3", err_underrun, wr_en_v, wr_addr);
        end
        clk_step(0, 1, PW'($urandom), 0);
        n_cmp++;
        if (g_ready_obs !== 1'b1 || wr_en_v !== 4'b0001) begin
            n_bad++;
            $display("FAIL simul_ready_next: got rdy %b en %b expected 1 0001", g_ready_obs, wr_en_v);
        end
        run_to_end(done_cnt, to);
        n_cmp++;
        if (to || done_cnt != 1 || err_underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_end: got to %b done %0d err %b expected 0 1 0", to, done_cnt, err_underrun);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        bit to;
        clk_step(1, 0, '0, 0);
        push_pixels(14);
        clk_step(1, 1, PW'($urandom), 0);
        n_cmp++;
        if (busy !== 1'b1 || start_rd !== 1'b1 || wr_en_v !== 4'b1000 || wr_addr !== 11'd2) begin
            n_bad++;
            $display("FAIL midrst_fs_ignored: got busy %b start %b en %b addr %0d expected 1 1 1000 2", busy, start_rd, wr_en_v, wr_addr);
        end
        #2;
        RESET = 1;
        #1;
        n_cmp++;
        if ({pix_ready, start_rd, frame_done, busy, err_underrun, wr_en_v} !== 9'd0 || wr_addr !== 11'd0 || wr_data !== '0) begin
            n_bad++;
            $display("FAIL midrst_immediate: got %b addr %0d data %0h expected all 0",
                     {pix_ready, start_rd, frame_done, busy, err_underrun, wr_en_v}, wr_addr, wr_data);
        end
        @(negedge clk);
        RESET = 0;
        @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            clk_step(0, 1, PW'($urandom), 1);
            n_cmp++;
            if (frame_done !== 1'b0 || busy !== 1'b0 || wr_en_v !== 4'd0) begin
                n_bad++;
                $display("FAIL midrst_idle_%0d: got done %b busy %b en %b expected 0 0 0000", i, frame_done, busy, wr_en_v);
            end
        end
        clk_step(1, 0, '0, 0);
        run_to_end(done_cnt, to);
        n_cmp++;
        if (to || done_cnt != 1 || err_underrun !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_fresh_frame: got to %b done %0d err %b busy %b expected 0 1 0 0", to, done_cnt, err_underrun, busy);
        end
    endtask

    task automatic test_random();
        bit to;
        for (int f = 0; f < 5; f++) begin
            clk_step(1, 0, '0, 0);
            to = 1;
            for (int n = 0; n < 400; n++) begin
                clk_step(($urandom % 16) == 0, ($urandom % 4) != 0, PW'($urandom), ($urandom % 6) == 0);
                n_cmp++;
                if (g_ready_obs !== g_ready_exp) begin
                    n_bad++;
                    $display("FAIL rnd_ready f%0d c%0d: got %b expected %b", f, n, g_ready_obs, g_ready_exp);
                end
                n_cmp++;
                if (wr_en_v !== e_wr_en) begin
                    n_bad++;
                    $display("FAIL rnd_wr_en f%0d c%0d: got %b expected %b", f, n, wr_en_v, e_wr_en);
                end
                n_cmp++;
                if (e_wr_en != 4'd0 && (wr_addr !== e_addr || wr_data !== e_data)) begin
                    n_bad++;
                    $display("FAIL rnd_wr_bus f%0d c%0d: got %0d %0h expected %0d %0h", f, n, wr_addr, wr_data, e_addr, e_data);
                end
                n_cmp++;
                if (start_rd !== 1'(m_reading) || frame_done !== 1'(e_done) || busy !== 1'(m_in_frame) || err_underrun !== 1'(m_err)) begin
                    n_bad++;
                    $display("FAIL rnd_ctrl f%0d c%0d: got start %b done %b busy %b err %b expected %b %b %b %b",
                             f, n, start_rd, frame_done, busy, err_underrun, m_reading, e_done, m_in_frame, m_err);
                end
                if (!m_in_frame) begin
                    to = 0;
                    break;
                end
            end
            n_cmp++;
            if (to) begin
                n_bad++;
                $display("FAIL rnd_timeout f%0d: got no frame end expected end within 400 cycles", f);
            end
            repeat (3) begin
                clk_step(0, 1, PW'($urandom), ($urandom % 2) == 0);
                n_cmp++;
                if (busy !== 1'b0 || frame_done !== 1'b0 || err_underrun !== 1'(m_err) || wr_en_v !== 4'd0) begin
                    n_bad++;
                    $display("FAIL rnd_idle f%0d: got busy %b done %b err %b en %b expected 0 0 %b 0000",
                             f, busy, frame_done, err_underrun, wr_en_v, m_err);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_backpressure();
        test_frame_end();
        test_underrun();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
